// File: rtl/mul_judge_pkg.sv
// Shared types for the multiplier subnormal judge pipeline.
//   sel_e : which operand (if any) takes the subnormal path
//   cls_e : IEEE-style operand class
//   class_of() : classifies an operand from its exponent/mantissa flags
package mul_judge_pkg;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_A_SUB = 2'd1,
        SEL_B_SUB = 2'd2,
        SEL_BOTH  = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        SUB  = 2'd1,
        NORM = 2'd2,
        SPEC = 2'd3
    } cls_e;

    // expo_zero: exponent field all zeros; expo_ones: all ones; mant_zero: mantissa zero
    function automatic cls_e class_of(input logic expo_zero,
                                      input logic expo_ones,
                                      input logic mant_zero);
        cls_e c;
        if (expo_ones) begin
            c = SPEC;
        end else if (expo_zero) begin
            c = mant_zero ? ZERO : SUB;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/mul_lzc.sv
// Combinational leading-zero counter.
//   data_i : W-bit value
//   cnt_o  : number of zeros above the highest set bit (W when data_i is zero)
module mul_lzc #(
    parameter int W = 23
) (
    input  logic [W-1:0]             data_i,
    output logic [$clog2(W+1)-1:0]   cnt_o
);

    localparam int CNT_W = $clog2(W+1);

    // Scan upwards so the highest set bit is the last (winning) assignment.
    always_comb begin
        cnt_o = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                cnt_o = CNT_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/mul_sub_judge_pipe.sv
// Two-stage judge for a floating-point multiplier front end. Classifies both
// operands, picks the subnormal path, and left-normalises the subnormal
// mantissa with its leading-zero count.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready is combinational from out_ready)
//   a_expo, a_mant,
//   b_expo, b_mant        : biased exponents and stored mantissas
//   out_valid / out_ready : result handshake
//   sel                   : sel_e path selection
//   mant_short            : mantissa of the normal partner (or all ones / zero)
//   sub_lzc, sub_norm     : leading-zero count and normalised subnormal mantissa
//   uflow                 : both operands subnormal
//   bypass                : an operand is zero, infinity or NaN
module mul_sub_judge_pipe
    import mul_judge_pkg::*;
#(
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [EXPO_W-1:0]             a_expo,
    input  logic [EXPO_W-1:0]             b_expo,
    input  logic [MANT_W-1:0]             a_mant,
    input  logic [MANT_W-1:0]             b_mant,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    sel,
    output logic [MANT_W:0]               mant_short,
    output logic [$clog2(MANT_W+1)-1:0]   sub_lzc,
    output logic [MANT_W-1:0]             sub_norm,
    output logic                          uflow,
    output logic                          bypass
);

    localparam int LZC_W = $clog2(MANT_W+1);

    // ---------------- handshake ----------------
    logic v1_q, v2_q;
    logic en1, en2;

    assign en2      = !v2_q || out_ready;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;

    // ---------------- stage 1: classify and select ----------------
    cls_e cls_a, cls_b;

    assign cls_a = class_of(a_expo == '0, &a_expo, a_mant == '0);
    assign cls_b = class_of(b_expo == '0, &b_expo, b_mant == '0);

    sel_e              sel1_d;
    logic              byp1_d, ufl1_d;
    logic [MANT_W:0]   ms1_d;
    logic [MANT_W-1:0] raw1_d;

    always_comb begin
        sel1_d = SEL_NONE;
        byp1_d = 1'b0;
        ufl1_d = 1'b0;
        ms1_d  = '0;
        raw1_d = '0;
        if (cls_a == ZERO || cls_a == SPEC || cls_b == ZERO || cls_b == SPEC) begin
            byp1_d = 1'b1;
        end else if (cls_a == SUB && cls_b == SUB) begin
            sel1_d = SEL_BOTH;
            ufl1_d = 1'b1;
        end else if (cls_a == SUB) begin
            sel1_d = SEL_A_SUB;
            ms1_d  = {1'b0, b_mant};
            raw1_d = a_mant;
        end else if (cls_b == SUB) begin
            sel1_d = SEL_B_SUB;
            ms1_d  = {1'b0, a_mant};
            raw1_d = b_mant;
        end else begin
            ms1_d  = '1;
        end
    end

    sel_e              sel1_q;
    logic              byp1_q, ufl1_q;
    logic [MANT_W:0]   ms1_q;
    logic [MANT_W-1:0] raw1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            sel1_q <= SEL_NONE;
            byp1_q <= 1'b0;
            ufl1_q <= 1'b0;
            ms1_q  <= '0;
            raw1_q <= '0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sel1_q <= sel1_d;
                byp1_q <= byp1_d;
                ufl1_q <= ufl1_d;
                ms1_q  <= ms1_d;
                raw1_q <= raw1_d;
            end
        end
    end

    // ---------------- stage 2: count and normalise ----------------
    logic [LZC_W-1:0] lzc_w;

    mul_lzc #(
        .W (MANT_W)
    ) u_lzc (
        .data_i (raw1_q),
        .cnt_o  (lzc_w)
    );

    // raw1_q is non-zero on the single-subnormal paths, so lzc_w < MANT_W there;
    // everywhere else the raw mantissa is zero and the count must be masked.
    logic              sub_path1;
    logic [LZC_W-1:0]  lzc2_d;
    logic [MANT_W-1:0] norm2_d;

    assign sub_path1 = (sel1_q == SEL_A_SUB) || (sel1_q == SEL_B_SUB);
    assign lzc2_d    = sub_path1 ? lzc_w : '0;
    assign norm2_d   = sub_path1 ? (raw1_q << lzc_w) : '0;

    sel_e              sel2_q;
    logic              byp2_q, ufl2_q;
    logic [MANT_W:0]   ms2_q;
    logic [LZC_W-1:0]  lzc2_q;
    logic [MANT_W-1:0] norm2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sel2_q  <= SEL_NONE;
            byp2_q  <= 1'b0;
            ufl2_q  <= 1'b0;
            ms2_q   <= '0;
            lzc2_q  <= '0;
            norm2_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sel2_q  <= sel1_q;
                byp2_q  <= byp1_q;
                ufl2_q  <= ufl1_q;
                ms2_q   <= ms1_q;
                lzc2_q  <= lzc2_d;
                norm2_q <= norm2_d;
            end
        end
    end

    assign out_valid  = v2_q;
    assign sel        = sel2_q;
    assign mant_short = ms2_q;
    assign sub_lzc    = lzc2_q;
    assign sub_norm   = norm2_q;
    assign uflow      = ufl2_q;
    assign bypass     = byp2_q;

endmodule

// File: tb/tb_mul_sub_judge_pipe.sv
module tb_mul_sub_judge_pipe;

    localparam int EW = 8;
    localparam int MW = 23;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [EW-1:0] a_expo, b_expo;
    logic [MW-1:0] a_mant, b_mant;
    logic [1:0]    sel;
    logic [MW:0]   mant_short;
    logic [LW-1:0] sub_lzc;
    logic [MW-1:0] sub_norm;
    logic          uflow, bypass;

    always #5 clk = ~clk;

    mul_sub_judge_pipe #(.EXPO_W(EW), .MANT_W(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_expo     (a_expo),
        .b_expo     (b_expo),
        .a_mant     (a_mant),
        .b_mant     (b_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel        (sel),
        .mant_short (mant_short),
        .sub_lzc    (sub_lzc),
        .sub_norm   (sub_norm),
        .uflow      (uflow),
        .bypass     (bypass)
    );

    typedef struct {
        logic [1:0]    sel;
        logic [MW:0]   ms;
        logic [LW-1:0] lzc;
        logic [MW-1:0] norm;
        logic          uflow;
        logic          bypass;
    } exp_t;

    typedef struct {
        logic [EW-1:0] ae;
        logic [MW-1:0] am;
        logic [EW-1:0] be;
        logic [MW-1:0] bm;
        exp_t          e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   popped = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, ".sel"},        32'(sel),        32'(e.sel));
        chk({tag, ".mant_short"}, 32'(mant_short), 32'(e.ms));
        chk({tag, ".sub_lzc"},    32'(sub_lzc),    32'(e.lzc));
        chk({tag, ".sub_norm"},   32'(sub_norm),   32'(e.norm));
        chk({tag, ".uflow"},      32'(uflow),      32'(e.uflow));
        chk({tag, ".bypass"},     32'(bypass),     32'(e.bypass));
    endtask

    // 0 zero, 1 subnormal, 2 normal, 3 inf/nan
    function automatic int op_class(input logic [EW-1:0] e, input logic [MW-1:0] m);
        if (e == 8'hFF) return 3;
        if (e == 0) return (m == 0) ? 0 : 1;
        return 2;
    endfunction

    function automatic int lead_zeros(input logic [MW-1:0] m);
        int n = 0;
        while (n < MW && m[MW-1-n] == 1'b0) n++;
        return n;
    endfunction

    function automatic exp_t model(input logic [EW-1:0] ae, input logic [MW-1:0] am,
                                   input logic [EW-1:0] be, input logic [MW-1:0] bm);
        exp_t r;
        int   ca, cb, n;
        ca = op_class(ae, am);
        cb = op_class(be, bm);
        r.sel = 2'd0; r.ms = '0; r.lzc = '0; r.norm = '0; r.uflow = 1'b0; r.bypass = 1'b0;
        if (ca == 0 || ca == 3 || cb == 0 || cb == 3) begin
            r.bypass = 1'b1;
        end else if (ca == 1 && cb == 1) begin
            r.sel = 2'd3;
            r.uflow = 1'b1;
        end else if (ca == 1) begin
            n = lead_zeros(am);
            r.sel = 2'd1; r.ms = {1'b0, bm}; r.lzc = LW'(n); r.norm = am << n;
        end else if (cb == 1) begin
            n = lead_zeros(bm);
            r.sel = 2'd2; r.ms = {1'b0, am}; r.lzc = LW'(n); r.norm = bm << n;
        end else begin
            r.ms = 24'hFFFFFF;
        end
        return r;
    endfunction

    // One clock of streaming: drive at negedge, settle, score what the next posedge will transfer.
    task automatic cyc(input logic iv, input logic [EW-1:0] ae, input logic [MW-1:0] am,
                       input logic [EW-1:0] be, input logic [MW-1:0] bm,
                       input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv; a_expo = ae; a_mant = am; b_expo = be; b_mant = bm;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                popped++;
                check_out("stream", e);
            end
        end
        acc = iv && in_ready;
        if (acc) exp_q.push_back(model(ae, am, be, bm));
    endtask

    function automatic logic [EW-1:0] rnd_expo();
        case ($urandom_range(0, 5))
            0, 1:    return '0;
            2:       return 8'hFF;
            default: return EW'($urandom_range(1, 254));
        endcase
    endfunction

    function automatic logic [MW-1:0] rnd_mant();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return MW'(1) << $urandom_range(0, MW - 1);
            2:       return 23'h7FFFFF;
            default: return MW'($urandom);
        endcase
    endfunction

    vec_t vecs[9];
    logic acc;
    logic [31:0] snap_ms, snap_misc;

    initial begin
        vecs[0] = '{8'h00, 23'h000001, 8'h80, 23'h400000, '{2'd1, 24'h400000, 5'd22, 23'h400000, 1'b0, 1'b0}};
        vecs[1] = '{8'h7F, 23'h123456, 8'h81, 23'h000001, '{2'd0, 24'hFFFFFF, 5'd0, 23'h0, 1'b0, 1'b0}};
        vecs[2] = '{8'h00, 23'h7FFFFF, 8'h00, 23'h000010, '{2'd3, 24'h0, 5'd0, 23'h0, 1'b1, 1'b0}};
        vecs[3] = '{8'hFF, 23'h7FFFFF, 8'h00, 23'h000010, '{2'd0, 24'h0, 5'd0, 23'h0, 1'b0, 1'b1}};
        vecs[4] = '{8'h90, 23'h0ABCDE, 8'h00, 23'h000300, '{2'd2, 24'h0ABCDE, 5'd13, 23'h600000, 1'b0, 1'b0}};
        vecs[5] = '{8'h00, 23'h000000, 8'h45, 23'h111111, '{2'd0, 24'h0, 5'd0, 23'h0, 1'b0, 1'b1}};
        vecs[6] = '{8'h01, 23'h7FFFFF, 8'h00, 23'h7FFFFF, '{2'd2, 24'h7FFFFF, 5'd0, 23'h7FFFFF, 1'b0, 1'b0}};
        vecs[7] = '{8'h00, 23'h7FFFFF, 8'hFE, 23'h000000, '{2'd1, 24'h000000, 5'd0, 23'h7FFFFF, 1'b0, 1'b0}};
        vecs[8] = '{8'h00, 23'h001000, 8'hFF, 23'h000000, '{2'd0, 24'h0, 5'd0, 23'h0, 1'b0, 1'b1}};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_expo = '0; b_expo = '0; a_mant = '0; b_mant = '0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.in_ready",  32'(in_ready),  1);
        check_out("rst", '{2'd0, 24'h0, 5'd0, 23'h0, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with exact 2-cycle latency.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            a_expo = vecs[i].ae; a_mant = vecs[i].am; b_expo = vecs[i].be; b_mant = vecs[i].bm;
            #1 chk("vec.in_ready", 32'(in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
            #1 chk("vec.lat1_out_valid", 32'(out_valid), 0);
            @(negedge clk);
            #1 chk("vec.lat2_out_valid", 32'(out_valid), 1);
            check_out($sformatf("vec%0d", i), vecs[i].e);
        end
        @(negedge clk);
        #1 chk("vec.drained", 32'(out_valid), 0);

        // Backpressure: three pairs with out_ready low, fill to two, then drain in order.
        popped = 0;
        cyc(1'b1, 8'h00, 23'h000001, 8'h80, 23'h400000, 1'b0, acc);
        chk("bp.acc1", 32'(acc), 1);
        cyc(1'b1, 8'h00, 23'h7FFFFF, 8'h00, 23'h000010, 1'b0, acc);
        chk("bp.acc2", 32'(acc), 1);
        cyc(1'b1, 8'h90, 23'h0ABCDE, 8'h00, 23'h000300, 1'b0, acc);
        chk("bp.full_in_ready", 32'(acc), 0);
        snap_ms   = 32'(mant_short);
        snap_misc = {sel, sub_lzc, uflow, bypass, out_valid};
        cyc(1'b1, 8'h90, 23'h0ABCDE, 8'h00, 23'h000300, 1'b0, acc);
        chk("bp.hold_in_ready", 32'(acc), 0);
        chk("bp.stable_ms",   32'(mant_short), snap_ms);
        chk("bp.stable_misc", {sel, sub_lzc, uflow, bypass, out_valid}, snap_misc);
        begin
            int guard = 0;
            acc = 1'b0;
            while (!acc && guard < 10) begin
                cyc(1'b1, 8'h90, 23'h0ABCDE, 8'h00, 23'h000300, 1'b1, acc);
                guard++;
            end
            chk("bp.acc3", 32'(acc), 1);
            guard = 0;
            while (exp_q.size() != 0 && guard < 10) begin
                cyc(1'b0, '0, '0, '0, '0, 1'b1, acc);
                guard++;
            end
            chk("bp.drain_count", 32'(popped), 3);
        end

        // Mid-operation reset with both stages full of bypass results.
        cyc(1'b1, 8'hFF, 23'h000000, 8'h10, 23'h000000, 1'b0, acc);
        cyc(1'b1, 8'h00, 23'h000000, 8'h10, 23'h000000, 1'b0, acc);
        cyc(1'b0, '0, '0, '0, '0, 1'b0, acc);
        chk("mr.full_valid", 32'(out_valid), 1);
        chk("mr.full_in_ready", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr.out_valid", 32'(out_valid), 0);
        chk("mr.bypass",    32'(bypass),    0);
        chk("mr.in_ready",  32'(in_ready),  1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cyc(1'b0, '0, '0, '0, '0, 1'b1, acc);

        // Random traffic with random backpressure against the model.
        begin
            int sent = 0;
            int cycles = 0;
            while (sent < 10000 && cycles < 60000) begin
                cyc($urandom_range(0, 9) < 8, rnd_expo(), rnd_mant(), rnd_expo(), rnd_mant(),
                    $urandom_range(0, 9) < 7, acc);
                if (acc) sent++;
                cycles++;
            end
            chk("rand.sent", 32'(sent), 32'd10000);
            cycles = 0;
            while (exp_q.size() != 0 && cycles < 10) begin
                cyc(1'b0, '0, '0, '0, '0, 1'b1, acc);
                cycles++;
            end
            chk("rand.leftover", 32'(exp_q.size()), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
